// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings and
// address-field helpers.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam int WORD_BYTES = 4;

  // Number of word-index bits taken from the byte address.
  function automatic int index_width(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-organised storage: synchronous write, combinational read, cleared by
// the synchronous active-low reset.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the datapath's data-memory port: one access at a time with a
// fixed wait-state latency and a one-cycle ready/error completion pulse.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        error,
  output logic        busy
);

  localparam int IDX_W = index_width(DEPTH_WORDS);
  localparam int CNT_W = ($clog2(WAIT_CYCLES + 1) < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   lat_idx;
  logic [31:0]        lat_data;
  logic               lat_write;
  logic               lat_err;

  logic               req;
  logic               req_err;
  logic [IDX_W-1:0]   req_idx;
  logic               we;
  logic [IDX_W-1:0]   waddr;
  logic [31:0]        wdata;
  logic [31:0]        rdata;

  assign req     = memRead | memWrite;
  assign req_idx = address[IDX_W+1:2];
  // Misaligned, beyond the array, or an ambiguous read+write request.
  assign req_err = (address[1:0] != 2'b00)
                 | (address[31:IDX_W+2] != '0)
                 | (memRead & memWrite);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_idx   <= '0;
      lat_data  <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && req) begin
        lat_idx   <= req_idx;
        lat_data  <= writeData;
        lat_write <= memWrite;
        lat_err   <= req_err;
        cnt       <= CNT_W'(WAIT_CYCLES);
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // The store commits on the edge that enters RESP; with no wait states that
  // edge is the capture edge itself, so the live request feeds the write.
  always_comb begin
    state_next = state;
    we         = 1'b0;
    waddr      = lat_idx;
    wdata      = lat_data;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            we         = memWrite & ~req_err;
            waddr      = req_idx;
            wdata      = writeData;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) begin
          state_next = RESP;
          we         = lat_write & ~lat_err;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (lat_idx),
    .rdata (rdata)
  );

  assign ready    = (state == RESP);
  assign error    = ready & lat_err;
  assign busy     = (state != IDLE);
  assign readData = (ready && !lat_write && !lat_err) ? rdata : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three builds (2, 0 and 3 wait states)
// driven from one stimulus process.
module tb_data_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        memRead   [3];
  logic        memWrite  [3];
  logic [31:0] address   [3];
  logic [31:0] writeData [3];
  logic [31:0] readData  [3];
  logic        ready     [3];
  logic        error     [3];
  logic        busy      [3];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(
      .DEPTH_WORDS (64),
      .WAIT_CYCLES ((g == 0) ? 2 : (g == 1) ? 0 : 3)
    ) dut (
      .clock     (clock),
      .reset     (reset),
      .memRead   (memRead[g]),
      .memWrite  (memWrite[g]),
      .address   (address[g]),
      .writeData (writeData[g]),
      .readData  (readData[g]),
      .ready     (ready[g]),
      .error     (error[g]),
      .busy      (busy[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Drives one request, waits (bounded) for ready and drops the request
  // during the ready cycle. lat counts cycles from the capture edge.
  task automatic access(input int d, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdat, output logic er, output int lat);
    rdat = 'x;
    er   = 1'bx;
    lat  = -1;
    @(negedge clock);
    memRead[d] = r; memWrite[d] = w; address[d] = a; writeData[d] = wd;
    @(posedge clock);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (ready[d]) begin
        lat = i; rdat = readData[d]; er = error[d];
        break;
      end
    end
    memRead[d] = 1'b0; memWrite[d] = 1'b0;
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  vec_t        vecs [13];
  logic [31:0] rdat;
  logic        er;
  int          lat;
  bit          saw;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0006, 32'h0,         32'h0,         1'b1};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0102, 32'h1111_1111, 32'h0,         1'b1};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0,         1'b1};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'h0,         1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_00FC, 32'hA5A5_A5A5, 32'h0,         1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_00FC, 32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         32'h0,         1'b1};
    vecs[11] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,         32'h0,         1'b1};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,         32'h0,         1'b0};

    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      memRead[d] = 1'b0; memWrite[d] = 1'b0; address[d] = '0; writeData[d] = '0;
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_ready[%0d]", d), 32'(ready[d]), 32'h0);
      check($sformatf("reset_busy[%0d]", d),  32'(busy[d]),  32'h0);
      check($sformatf("reset_error[%0d]", d), 32'(error[d]), 32'h0);
      check($sformatf("reset_rdata[%0d]", d), readData[d],   32'h0);
    end
    reset = 1'b1;

    // Two-wait-state build: table of stores/loads including error cases.
    for (int i = 0; i < 13; i++) begin
      access(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rdat, er, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
      check($sformatf("v%0d_error", i),   32'(er),  32'(vecs[i].exp_err));
      check($sformatf("v%0d_rdata", i),   rdat,     vecs[i].exp_data);
    end

    // Reset during WAIT of a store: access aborted, nothing committed.
    @(negedge clock);
    memWrite[0] = 1'b1; address[0] = 32'h8; writeData[0] = 32'h5555_AAAA;
    @(posedge clock);
    @(negedge clock);
    check("abort_busy_in_wait", 32'(busy[0]), 32'h1);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    memWrite[0] = 1'b0;
    check("abort_busy_after_reset", 32'(busy[0]), 32'h0);
    check("abort_ready_after_reset", 32'(ready[0]), 32'h0);
    saw = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (ready[0]) saw = 1'b1;
    end
    check("abort_no_ready", 32'(saw), 32'h0);
    access(0, 1'b1, 1'b0, 32'h8, 32'h0, rdat, er, lat);
    check("abort_load_rdata", rdat, 32'h0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, rdat, er, lat);
    check("abort_mem_cleared", rdat, 32'h0);

    // Zero-wait-state build: single access latency, then a held request.
    access(1, 1'b0, 1'b1, 32'h4, 32'h0BAD_F00D, rdat, er, lat);
    check("w0_store_latency", 32'(lat), 32'd1);
    access(1, 1'b1, 1'b0, 32'h4, 32'h0, rdat, er, lat);
    check("w0_load_latency", 32'(lat), 32'd1);
    check("w0_load_rdata", rdat, 32'h0BAD_F00D);
    @(negedge clock);
    memRead[1] = 1'b1; address[1] = 32'h4;
    @(posedge clock);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      check($sformatf("w0_held_ready_c%0d", i), 32'(ready[1]), 32'(i % 2));
      if (i % 2 == 1) check($sformatf("w0_held_rdata_c%0d", i), readData[1], 32'h0BAD_F00D);
      if (i == 5) memRead[1] = 1'b0;
    end

    // Three-wait-state build: request dropped and address moved mid-WAIT.
    access(2, 1'b0, 1'b1, 32'h10, 32'h600D_CAFE, rdat, er, lat);
    check("w3_store_latency", 32'(lat), 32'd4);
    access(2, 1'b0, 1'b1, 32'h40, 32'h0000_BEEF, rdat, er, lat);
    check("w3_store2_error", 32'(er), 32'h0);
    @(negedge clock);
    memRead[2] = 1'b1; address[2] = 32'h10;
    @(posedge clock);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      check($sformatf("w3_busy_c%0d", i),  32'(busy[2]),  32'(i <= 4));
      check($sformatf("w3_ready_c%0d", i), 32'(ready[2]), 32'(i == 4));
      if (i == 4) check("w3_rdata_latched_addr", readData[2], 32'h600D_CAFE);
      if (i == 1) begin
        memRead[2] = 1'b0; address[2] = 32'h40;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the datapath's data-memory interface (memRead/memWrite/address/writeData).
- Serves one load/store at a time with a fixed, parameterised wait-state latency.
- Signals completion with a one-cycle `ready` pulse, so the multi-cycle control FSM can stall on memory.
- Sits between the multi-cycle datapath's ALU-result/store-data path and the writeback mux.

Parameters:
- DEPTH_WORDS, 64: number of 32-bit words stored; power of two, ≥ 2.
- WAIT_CYCLES, 2: extra cycles between request capture and `ready`; range 0 to 15.

Ports:
- clock  in  1  single system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset; reset==0 at a posedge resets the block.
- memRead  in  1  load request, held by the initiator until `ready`.
- memWrite  in  1  store request, held by the initiator until `ready`.
- address  in  32  byte address; word index = address[log2(DEPTH_WORDS)+1:2].
- writeData  in  32  store data, sampled with the request.
- readData  out  32  load result; valid only while ready==1, otherwise 0.
- ready  out  1  one-cycle completion pulse.
- error  out  1  qualifies `ready`; 1 means the access was rejected.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset==0 at posedge):
  - state goes to IDLE; wait counter is 0; the latched request is cleared.
  - All DEPTH_WORDS words are cleared to 0.
  - readData=0, ready=0, error=0, busy=0 from the next cycle.
  - A reset during WAIT or RESP aborts the access; a pending store is not committed.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Samples requests when memRead|memWrite is high.
  - Latches address, writeData and op.
  - Computes the error flag, set if any of:
    - address[1:0] != 0 (misaligned);
    - address bits above the index field are nonzero (out of range);
    - memRead and memWrite are both high.
  - If WAIT_CYCLES==0, goes to RESP. Otherwise goes to WAIT with cnt=WAIT_CYCLES.
- WAIT:
  - cnt decrements each cycle.
  - When cnt==1, goes to RESP.
  - On the edge entering RESP, a non-error store writes the latched data to the latched word index.
- RESP:
  - ready=1 for exactly one cycle. error=latched flag.
  - Load without error: readData=mem[index], read combinationally from the array. Any other case: readData=0.
  - Always returns to IDLE next cycle.
- Latency:
  - A request sampled at posedge N gets ready==1 in cycle N+1+WAIT_CYCLES.
  - Store data is visible to a load issued in the cycle after `ready`.
- Handshake rules:
  - The initiator drops its request on the edge after `ready`.
  - Requests during WAIT/RESP are ignored. Input changes after capture do not affect the access in flight.
  - Dropping the request mid-WAIT does not cancel the access; it still completes with `ready`.
  - A request held through RESP into IDLE is taken as a new access (back-to-back allowed). Minimum issue interval is WAIT_CYCLES+2 cycles.
- Errored accesses never modify memory.
- cnt width: max(1, clog2(WAIT_CYCLES+1)); it never wraps.

Decomposition:
- Shared package data_mem_pkg holds:
  - state encodings IDLE=2'b00, WAIT=2'b01, RESP=2'b10;
  - WORD_BYTES=4;
  - helper constant for the index width, log2(DEPTH_WORDS).
- One sub-module, data_mem_array:
  - DEPTH_WORDS x 32 storage;
  - synchronous write enable;
  - combinational read;
  - synchronous active-low clear on reset.
- The FSM, counter and request latch stay in data_mem_responder.

Test Plan:
1. Store then load, WAIT_CYCLES=2:
   - memWrite, address=0x0000_0010, writeData=0xDEAD_BEEF sampled at cycle 0 -> ready=1, error=0 in cycle 3.
   - Then memRead at address 0x10 -> readData=0xDEAD_BEEF, ready in cycle 3 relative to its sample.
2. Misaligned load at address 0x0000_0006 -> ready with error=1 and readData=0 at N+3.
   - Same for a store to 0x0000_0102 (out of range with DEPTH_WORDS=64): error=1, and a later load of word 0 returns its prior value unchanged.
3. memRead and memWrite both high at address 0x20, writeData=0x1234_5678 -> error=1, and a later load of 0x20 returns 0.
4. Reset asserted (reset=0) during WAIT of a store of 0x5555_AAAA to 0x8 -> no ready pulse and busy=0 next cycle; a subsequent load of 0x8 returns 0.
5. WAIT_CYCLES=0 build:
   - a load sampled at cycle N gives ready at N+1;
   - a held request re-issues at N+2;
   - two back-to-back loads give two ready pulses at N+1 and N+3.
6. Request dropped after one cycle with WAIT_CYCLES=3 and address changed to 0x40 mid-WAIT -> ready at N+4 with data from the originally latched address; busy=1 for cycles N+1 through N+4.
